hazard_unit_param: RTL and testbench
====================================

// Module: hazard_unit_param
// PURPOSE
//  Parametrised load-use/forwarding controller for the RV32I pipeline. Decodes the ID-stage instruction, tracks
//  in-flight destinations in a DEPTH-entry scoreboard shift register, raises a combinational stall on load-use
//  hazards, and registers per-source forwarding selects consumed by the EX-stage operand muxes.
//  Adds full RV32I source/dest decode, configurable load latency, flush and a stall-cycle counter.
// PARAMETERS
//  DEPTH     2   scoreboard entries; entry k = producer k+1 stages ahead of ID (entry 0 = EX)
//  LOAD_LAT  2   earliest fwd_sel value at which load data is forwardable (1..DEPTH)
//  REG_AW    5   register address width
//  CNT_W     16  stall counter width
//  SEL_W     $clog2(DEPTH+1)  forwarding select width (derived localparam)
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous active-low reset
//  inst       in   32      instruction in ID
//  inst_valid in   1       inst is a real instruction (0 = bubble)
//  flush      in   1       squash ID instruction this cycle
//  stall      out  1       hold PC and IF/ID; insert bubble into EX (combinational)
//  fwd_sel1   out  SEL_W   EX rs1 source: 0 = regfile, k = result of stage k after EX
//  fwd_sel2   out  SEL_W   EX rs2 source, same encoding
//  stall_cnt  out  CNT_W   saturating count of stall cycles
// BEHAVIOUR
//  Reset (rst=0, async): scoreboard entries invalid, fwd_sel1/2=0, stall_cnt=0; stall forced 0.
//  Decode: uses_rs1 unless LUI/AUIPC/JAL/ECALL; uses_rs2 only RTYPE, STORE(0100011), BRANCH(1100011).
//   writes_rd for LOAD, OP-IMM, RTYPE, LUI, AUIPC, JAL, JALR with rd!=0; is_load = opcode 0000011.
//   Source regs equal to x0 never match. inst_valid=0 => no sources, no dest.
//  Match: for source s, youngest valid entry k (lowest index) with rd==s wins; older matches ignored.
//   candidate sel = k+1. No match => sel 0.
//  Stall (comb): inst_valid & ~flush & some used source's winning entry is_load with k+1 < LOAD_LAT.
//  Clock edge (rst=1), scoreboard: entries shift up by one (entry DEPTH-1 discarded); entry 0 loads
//   {valid, rd, is_load} of ID inst if inst_valid & ~stall & ~flush & writes_rd, else invalid (bubble).
//  Clock edge, fwd_sel1/2: register candidate sel if inst_valid & ~stall & ~flush & source used, else 0.
//   Latency: select valid in the cycle the consumer is in EX (one edge after decode).
//  Stall resolves itself: load advances one entry per cycle; stall lasts LOAD_LAT-(k+1) cycles.
//  stall_cnt: +1 each edge with stall=1; saturates at 2^CNT_W-1, no wrap.
//  flush and stall together: flush wins (stall=0, bubble inserted, counter not incremented).
//  Reset mid-stall: stall drops immediately, all entries cleared, no stale forwarding after release.
//  Both sources may match the same or different entries independently; both may stall simultaneously.
// TESTING
//  T1 ALU chain: add x5,x1,x2 then add x6,x5,x3 -> no stall; fwd_sel1=1 for 2nd add in EX; fwd_sel2=0.
//  T2 load-use: lw x7,0(x1) then add x8,x7,x7 -> stall=1 for 1 cycle, stall_cnt=1; next EX fwd_sel1=fwd_sel2=2.
//  T3 priority: addi x4,x0,1; addi x4,x0,2; sub x9,x4,x4 -> fwd_sel1=fwd_sel2=1 (youngest), not 2.
//  T4 x0/no-source: addi x0,x0,5 then add x1,x0,x0, and lui x3 after lw x3 -> no stall, sels 0.
//  T5 flush: lw x7 then add x8,x7,x0 with flush=1 -> stall=0, sels 0, stall_cnt unchanged.
//  T6 params/reset: DEPTH=3,LOAD_LAT=3, lw x7 then use -> 2 stall cycles, fwd_sel1=3; assert rst mid-stall -> all outputs 0.

Source files
------------

// File: rtl/hazard_unit_param.sv
// hazard_unit_param: load-use stall and forwarding-select controller for an
// RV32I pipeline. The ID instruction is decoded and its sources are compared
// against a DEPTH-entry scoreboard of in-flight destinations (entry 0 = EX).
// Sources that hit a load which is still too young raise a combinational stall.
// Otherwise the matching stage index is registered as that source's
// forwarding select for the EX-stage operand muxes.
module hazard_unit_param #(
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 2,
  parameter int REG_AW   = 5,
  parameter int CNT_W    = 16,
  localparam int SEL_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst,
  input  logic             inst_valid,
  input  logic             flush,
  output logic             stall,
  output logic [SEL_W-1:0] fwd_sel1,
  output logic [SEL_W-1:0] fwd_sel2,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [31:0] INST_ECALL = 32'h0000_0073;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [6:0]        opc;
  logic [REG_AW-1:0] rs1, rs2, rd;
  logic              use1, use2, wr_rd, is_ld;
  logic [SEL_W-1:0]  sel1_c, sel2_c;
  logic              ld1_c, ld2_c, haz1, haz2, adv;

  // Scoreboard: valid/load flags are control (reset), rd is data (no reset).
  logic [DEPTH-1:0]  sb_vld;
  logic [DEPTH-1:0]  sb_ld;
  logic [REG_AW-1:0] sb_rd [DEPTH];

  // Decode the ID instruction: which sources are read, whether rd is written.
  always_comb begin
    opc   = inst[6:0];
    rs1   = REG_AW'(inst[19:15]);
    rs2   = REG_AW'(inst[24:20]);
    rd    = REG_AW'(inst[11:7]);
    use1  = inst_valid && (rs1 != '0) &&
            !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL || inst == INST_ECALL);
    use2  = inst_valid && (rs2 != '0) &&
            (opc == OPC_OP || opc == OPC_STORE || opc == OPC_BRANCH);
    wr_rd = inst_valid && (rd != '0) &&
            (opc == OPC_LOAD || opc == OPC_OPIMM || opc == OPC_OP || opc == OPC_LUI ||
             opc == OPC_AUIPC || opc == OPC_JAL || opc == OPC_JALR);
    is_ld = (opc == OPC_LOAD);
  end

  // Youngest-match search: scan oldest to youngest so the lowest index wins.
  always_comb begin
    sel1_c = '0;
    sel2_c = '0;
    ld1_c  = 1'b0;
    ld2_c  = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (sb_vld[k] && sb_rd[k] == rs1) begin
        sel1_c = SEL_W'(k + 1);
        ld1_c  = sb_ld[k];
      end
      if (sb_vld[k] && sb_rd[k] == rs2) begin
        sel2_c = SEL_W'(k + 1);
        ld2_c  = sb_ld[k];
      end
    end
    if (!use1) begin
      sel1_c = '0;
      ld1_c  = 1'b0;
    end
    if (!use2) begin
      sel2_c = '0;
      ld2_c  = 1'b0;
    end
  end

  // Stall when a used source's producer is a load not yet at a forwardable stage;
  // flush overrides, and reset forces the stall low.
  always_comb begin
    haz1  = ld1_c && (int'(sel1_c) < LOAD_LAT);
    haz2  = ld2_c && (int'(sel2_c) < LOAD_LAT);
    stall = rst && inst_valid && !flush && (haz1 || haz2);
    adv   = inst_valid && !stall && !flush;
  end

  // ---- ID -> EX boundary: scoreboard shift and forwarding selects ----

  // Scoreboard control bits: shift toward older stages, insert ID dest or a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_vld <= '0;
      sb_ld  <= '0;
    end else begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        sb_vld[k] <= sb_vld[k-1];
        sb_ld[k]  <= sb_ld[k-1];
      end
      sb_vld[0] <= adv && wr_rd;
      sb_ld[0]  <= adv && wr_rd && is_ld;
    end
  end

  // Scoreboard destination registers follow the same shift; validity is tracked above.
  always_ff @(posedge clk) begin
    for (int k = DEPTH - 1; k >= 1; k--) begin
      sb_rd[k] <= sb_rd[k-1];
    end
    sb_rd[0] <= rd;
  end

  // Forwarding selects for the instruction entering EX; bubbles get regfile (0).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_sel1 <= '0;
      fwd_sel2 <= '0;
    end else begin
      fwd_sel1 <= adv ? sel1_c : '0;
      fwd_sel2 <= adv ? sel2_c : '0;
    end
  end

  // Stall-cycle counter, saturating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_hazard_unit_param.sv
// Testbench for hazard_unit_param: a table of single-cycle vectors on the
// default configuration, plus hand-written sequences on a DEPTH=3/LOAD_LAT=3
// instance with a 2-bit counter for multi-cycle stalls, saturation and reset.
module tb_hazard_unit_param;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] inst = '0;
  logic        inst_valid = 1'b0;
  logic        flush = 1'b0;

  logic        stall_a, stall_b;
  logic [1:0]  sel1_a, sel2_a, sel1_b, sel2_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_unit_param dut_a (
    .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid), .flush(flush),
    .stall(stall_a), .fwd_sel1(sel1_a), .fwd_sel2(sel2_a), .stall_cnt(cnt_a)
  );

  hazard_unit_param #(.DEPTH(3), .LOAD_LAT(3), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid), .flush(flush),
    .stall(stall_b), .fwd_sel1(sel1_b), .fwd_sel2(sel2_b), .stall_cnt(cnt_b)
  );

  function automatic logic [31:0] r_add(input int rd, input int a, input int b);
    return {7'b0000000, 5'(b), 5'(a), 3'b000, 5'(rd), 7'b0110011};
  endfunction
  function automatic logic [31:0] r_sub(input int rd, input int a, input int b);
    return {7'b0100000, 5'(b), 5'(a), 3'b000, 5'(rd), 7'b0110011};
  endfunction
  function automatic logic [31:0] i_addi(input int rd, input int a, input int imm);
    return {12'(imm), 5'(a), 3'b000, 5'(rd), 7'b0010011};
  endfunction
  function automatic logic [31:0] i_lw(input int rd, input int a, input int imm);
    return {12'(imm), 5'(a), 3'b010, 5'(rd), 7'b0000011};
  endfunction
  function automatic logic [31:0] u_lui(input int rd, input int imm);
    return {20'(imm), 5'(rd), 7'b0110111};
  endfunction

  typedef struct {
    logic [31:0] ins;
    logic        vld;
    logic        fl;
    logic        st;
    int          s1;
    int          s2;
    int          cnt;
    string       nm;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [31:0] i, input logic v, input logic f,
                              input logic s, input int e1, input int e2, input int ec,
                              input string n);
    vec_t r;
    r.ins = i; r.vld = v; r.fl = f; r.st = s; r.s1 = e1; r.s2 = e2; r.cnt = ec; r.nm = n;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Apply one instruction: check the combinational stall mid-cycle, then the
  // registered selects and counter just after the following edge.
  task automatic step(input bit useb, input logic [31:0] i, input logic v, input logic f,
                      input logic es, input int e1, input int e2, input int ec,
                      input string nm);
    inst = i; inst_valid = v; flush = f;
    #2;
    chk({nm, ".stall"}, useb ? int'(stall_b) : int'(stall_a), int'(es));
    @(posedge clk);
    #1;
    chk({nm, ".sel1"}, useb ? int'(sel1_b) : int'(sel1_a), e1);
    chk({nm, ".sel2"}, useb ? int'(sel2_b) : int'(sel2_a), e2);
    chk({nm, ".cnt"},  useb ? int'(cnt_b)  : int'(cnt_a),  ec);
  endtask

  task automatic do_reset();
    inst = '0; inst_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst.stall_a", int'(stall_a), 0);
    chk("rst.sel_a",   int'(sel1_a) + int'(sel2_a), 0);
    chk("rst.cnt_a",   int'(cnt_a), 0);
    chk("rst.cnt_b",   int'(cnt_b), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // T1 ALU chain
    tbl.push_back(mk(r_add(5,1,2), 1, 0, 0, 0, 0, 0, "t1_add5"));
    tbl.push_back(mk(r_add(6,5,3), 1, 0, 0, 1, 0, 0, "t1_add6"));
    tbl.push_back(mk('0, 0, 0, 0, 0, 0, 0, "t1_bub0"));
    tbl.push_back(mk('0, 0, 0, 0, 0, 0, 0, "t1_bub1"));
    // T2 load-use
    tbl.push_back(mk(i_lw(7,1,0),  1, 0, 0, 0, 0, 0, "t2_lw"));
    tbl.push_back(mk(r_add(8,7,7), 1, 0, 1, 0, 0, 1, "t2_use_stall"));
    tbl.push_back(mk(r_add(8,7,7), 1, 0, 0, 2, 2, 1, "t2_use_go"));
    tbl.push_back(mk('0, 0, 0, 0, 0, 0, 1, "t2_bub0"));
    tbl.push_back(mk('0, 0, 0, 0, 0, 0, 1, "t2_bub1"));
    // T3 youngest match wins
    tbl.push_back(mk(i_addi(4,0,1), 1, 0, 0, 0, 0, 1, "t3_addi1"));
    tbl.push_back(mk(i_addi(4,0,2), 1, 0, 0, 0, 0, 1, "t3_addi2"));
    tbl.push_back(mk(r_sub(9,4,4),  1, 0, 0, 1, 1, 1, "t3_sub"));
    tbl.push_back(mk('0, 0, 0, 0, 0, 0, 1, "t3_bub0"));
    tbl.push_back(mk('0, 0, 0, 0, 0, 0, 1, "t3_bub1"));
    // T4 x0 and no-source instructions
    tbl.push_back(mk(i_addi(0,0,5), 1, 0, 0, 0, 0, 1, "t4_addi_x0"));
    tbl.push_back(mk(r_add(1,0,0),  1, 0, 0, 0, 0, 1, "t4_add_x0x0"));
    tbl.push_back(mk('0, 0, 0, 0, 0, 0, 1, "t4_bub0"));
    tbl.push_back(mk('0, 0, 0, 0, 0, 0, 1, "t4_bub1"));
    tbl.push_back(mk(i_lw(3,1,0),       1, 0, 0, 0, 0, 1, "t4_lw3"));
    tbl.push_back(mk(u_lui(3,32'h12345), 1, 0, 0, 0, 0, 1, "t4_lui3"));
    tbl.push_back(mk('0, 0, 0, 0, 0, 0, 1, "t4_bub2"));
    tbl.push_back(mk('0, 0, 0, 0, 0, 0, 1, "t4_bub3"));
    // T5 flush beats stall; afterwards the squashed slot was a bubble
    tbl.push_back(mk(i_lw(7,1,0),  1, 0, 0, 0, 0, 1, "t5_lw"));
    tbl.push_back(mk(r_add(8,7,0), 1, 1, 0, 0, 0, 1, "t5_flush"));
    tbl.push_back(mk(r_add(8,7,0), 1, 0, 0, 2, 0, 1, "t5_refetch"));
    tbl.push_back(mk('0, 0, 0, 0, 0, 0, 1, "t5_bub0"));

    do_reset();
    foreach (tbl[n]) begin
      step(1'b0, tbl[n].ins, tbl[n].vld, tbl[n].fl, tbl[n].st,
           tbl[n].s1, tbl[n].s2, tbl[n].cnt, tbl[n].nm);
    end

    // T6 DEPTH=3, LOAD_LAT=3 instance: two-cycle stall, forward from stage 3
    do_reset();
    step(1'b1, i_lw(7,1,0),  1, 0, 0, 0, 0, 0, "t6_lw");
    step(1'b1, r_add(8,7,0), 1, 0, 1, 0, 0, 1, "t6_stall1");
    step(1'b1, r_add(8,7,0), 1, 0, 1, 0, 0, 2, "t6_stall2");
    step(1'b1, r_add(8,7,0), 1, 0, 0, 3, 0, 2, "t6_go");
    for (int n = 0; n < 3; n++) step(1'b1, '0, 0, 0, 0, 0, 0, 2, "t6_bub");
    // Second load-use drives the 2-bit counter into saturation
    step(1'b1, i_lw(7,1,0),  1, 0, 0, 0, 0, 2, "t6_lw2");
    step(1'b1, r_add(8,7,0), 1, 0, 1, 0, 0, 3, "t6_sat1");
    step(1'b1, r_add(8,7,0), 1, 0, 1, 0, 0, 3, "t6_sat_hold");
    step(1'b1, r_add(8,7,0), 1, 0, 0, 3, 0, 3, "t6_go2");
    for (int n = 0; n < 3; n++) step(1'b1, '0, 0, 0, 0, 0, 0, 3, "t6_bub2");

    // Reset asserted in the middle of a stall
    step(1'b1, i_lw(7,1,0), 1, 0, 0, 0, 0, 3, "t6_lw3");
    inst = r_add(8,7,0); inst_valid = 1'b1; flush = 1'b0;
    #2;
    chk("t6_pre_rst.stall", int'(stall_b), 1);
    rst = 1'b0;
    #1;
    chk("t6_rst.stall", int'(stall_b), 0);
    chk("t6_rst.sel1",  int'(sel1_b), 0);
    chk("t6_rst.sel2",  int'(sel2_b), 0);
    chk("t6_rst.cnt",   int'(cnt_b), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, r_add(8,7,0), 1, 0, 0, 0, 0, 0, "t6_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
